voice_allocator: RTL
====================

// Module: voice_allocator
// PURPOSE
//  Maps incoming MIDI note-on/off events onto the N_VOICES oscillator slots of the synth.
//  Runs in the system clk domain, between the MCU command decode and the wave_gens config.
//  Per event: picks the voice (reuse same note > free > oldest releasing > oldest gated).
//  Per voice: drives gate/note/velocity, and pulses a retrigger bit that maps to the
//  envelope-reset command bit.
// PARAMETERS
//  N_VOICES         8      number of voice slots, equals `N_OSCILLATORS
//  AGE_W            16     width of per-voice age counter, in sample ticks; saturating
//  RELEASE_TIMEOUT  48000  sample ticks after note-off before a slot is force-freed (1 s)
// PORTS
//  clk           in   1         system clock
//  rstn          in   1         asynchronous, active-low reset
//  sample_tick   in   1         one-clk strobe per audio sample, already in the clk domain
//  note_valid    in   1         event valid
//  note_ready    out  1         event accepted when note_valid && note_ready
//  note_on       in   1         1 = note-on, 0 = note-off
//  note_num      in   7         MIDI note number
//  note_vel      in   7         MIDI velocity; note-on with vel 0 is treated as note-off
//  all_off       in   1         panic: frees all voices
//  release_done  in   N_VOICES  envelope finished release, per voice
//  voice_gate    out  N_VOICES  key held
//  voice_busy    out  N_VOICES  slot owned (gated or releasing)
//  voice_note    out  N_VOICES x 7  note per slot
//  voice_vel     out  N_VOICES x 7  velocity per slot
//  voice_retrig  out  N_VOICES  one-clk pulse on (re)start of a slot
//  steal         out  1         one-clk pulse when a busy slot is taken by a new note
// BEHAVIOUR
//  Reset: all outputs 0 except note_ready=1; FSM in IDLE; ages and release timers 0.
//  FSM states and transitions:
//   - IDLE: accepts one event on the handshake and latches it. note_ready=1 only here.
//   - SCAN: visits voice k at cycle k, for N_VOICES cycles.
//   - COMMIT: applies the result, then returns to IDLE.
//  Latency: COMMIT outputs are visible exactly N_VOICES+2 clk after the handshake edge.
//  SCAN priority for note-on, ties broken by lowest index:
//   1. busy slot with the same note_num;
//   2. free slot;
//   3. releasing slot (busy && !gate) with the largest age;
//   4. gated slot with the largest age.
//  Note-on COMMIT on the chosen slot:
//   - busy=1, gate=1, note and vel loaded;
//   - age=0, release timer=0;
//   - voice_retrig=1 for 1 clk;
//   - steal=1 only if priority 3 or 4 was used.
//  Note-off: all busy && gate slots with a matching note get gate=0 and release timer=0.
//   No match: the event is accepted and ignored.
//  Releasing slot is freed (busy=0; note and vel kept) when either holds:
//   - release_done[i] is sampled 1;
//   - its release timer reaches RELEASE_TIMEOUT.
//  This is evaluated every clk, in any FSM state.
//  Age and timers:
//   - ages of busy slots increment on sample_tick and saturate at 2^AGE_W-1;
//   - release timers increment on sample_tick while releasing and saturate at RELEASE_TIMEOUT.
//  sample_tick during SCAN or COMMIT is held in a 1-bit pending flag.
//   The flag is applied in the first IDLE cycle, so ages are frozen while they are compared.
//   A second tick while the flag is already set is lost; this cannot occur, since
//   N_VOICES+2 clk is much less than the clk/sample ratio.
//  release_done on the slot being committed in the same cycle: COMMIT wins and the slot stays busy.
//  all_off has the highest priority, synchronous, in any state:
//   - gate=0, busy=0, ages and timers 0, pending flag cleared;
//   - FSM to IDLE and the latched event is dropped;
//   - no retrig or steal pulse.
//  rstn asserted mid-SCAN: immediate async return to reset values.
// STRUCTURE
//  Shared package (synth package, next to wavegen_t):
//   - voice_t {note[6:0], vel[6:0], gate, busy, age[AGE_W-1:0]};
//   - alloc_state_t {IDLE, SCAN, COMMIT};
//   - constants VOICE_AGE_W and VOICE_RELEASE_TIMEOUT.
//  Sub-module voice_slot, generated N_VOICES times:
//   - holds one voice_t and its release timer, with age/timer saturation;
//   - handles release_done and timeout freeing, load/off/clear strobes and the retrig pulse.
//  Top level holds the event latch, the FSM, the SCAN best-candidate registers and the
//   pending-tick flag.
// TESTING
//  1. Reset, then idle 100 clk -> all gates, busy, retrig and steal are 0; note_ready=1.
//  2. Note-on 60/100 -> voice0 gate=1, note=60, vel=100; retrig pulse exactly N_VOICES+2
//     clk after the handshake; note_ready=0 for N_VOICES+2 cycles.
//  3. Note-on 60..67, with one sample_tick between each, then note-on 72 -> voice0 is
//     reused (note=72); steal=1 for 1 clk.
//  4. Note-on 60 twice -> the same voice retriggers twice; other slots stay free; steal=0.
//  5. Note-off 60:
//     - release_done[0] 3 clk later -> busy[0]=0 on the next clk;
//     - repeat without release_done -> busy[0]=0 after 48000 ticks;
//     - note-on 64 with vel=0 behaves as note-off.
//  6. Three voices active, then all_off mid-SCAN -> all busy=0 on the next clk; no retrig;
//     note_ready=1.

Source files
------------

// File: rtl/voice_allocator_pkg.sv
// Shared types and constants for the voice allocator and its slots.
package voice_allocator_pkg;

  localparam int VOICE_AGE_W           = 16;
  localparam int VOICE_RELEASE_TIMEOUT = 48000;

  typedef struct packed {
    logic [6:0]             note;
    logic [6:0]             vel;
    logic                   gate;
    logic                   busy;
    logic [VOICE_AGE_W-1:0] age;
  } voice_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } alloc_state_t;

  // Candidate class for a note-on; lower value wins.
  typedef enum logic [1:0] {
    CLS_SAME  = 2'd0,
    CLS_FREE  = 2'd1,
    CLS_REL   = 2'd2,
    CLS_GATED = 2'd3
  } cand_cls_t;

  function automatic cand_cls_t classify(input logic       busy,
                                         input logic       gate,
                                         input logic [6:0] slot_note,
                                         input logic [6:0] ev_note);
    cand_cls_t c;
    if (busy && (slot_note == ev_note)) c = CLS_SAME;
    else if (!busy)                     c = CLS_FREE;
    else if (!gate)                     c = CLS_REL;
    else                                c = CLS_GATED;
    return c;
  endfunction

endpackage

// File: rtl/voice_slot.sv
// One voice slot: note state, age, release timer and retrigger pulse.
module voice_slot
  import voice_allocator_pkg::*;
#(
  parameter int AGE_W           = VOICE_AGE_W,
  parameter int RELEASE_TIMEOUT = VOICE_RELEASE_TIMEOUT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_tick,
  input  logic       i_load,
  input  logic       i_off,
  input  logic       i_clear,
  input  logic [6:0] i_note,
  input  logic [6:0] i_vel,
  input  logic       i_release_done,
  output voice_t     o_voice,
  output logic       o_retrig
);

  localparam int TMR_W = $clog2(RELEASE_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMO = TMR_W'(RELEASE_TIMEOUT);
  localparam logic [VOICE_AGE_W-1:0] AGE_MAX =
    VOICE_AGE_W'((64'd1 << AGE_W) - 64'd1);

  voice_t           r_voice;
  logic [TMR_W-1:0] r_tmr;
  logic             r_retrig;
  logic             w_rel;

  assign w_rel    = r_voice.busy && !r_voice.gate;
  assign o_voice  = r_voice;
  assign o_retrig = r_retrig;

  // Slot state: clear beats load, load beats release freeing; ages and timers saturate.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_voice  <= '0;
      r_tmr    <= '0;
      r_retrig <= 1'b0;
    end else if (i_clear) begin
      r_voice.gate <= 1'b0;
      r_voice.busy <= 1'b0;
      r_voice.age  <= '0;
      r_tmr        <= '0;
      r_retrig     <= 1'b0;
    end else if (i_load) begin
      r_voice.note <= i_note;
      r_voice.vel  <= i_vel;
      r_voice.gate <= 1'b1;
      r_voice.busy <= 1'b1;
      r_voice.age  <= '0;
      r_tmr        <= '0;
      r_retrig     <= 1'b1;
    end else begin
      r_retrig <= 1'b0;
      if (i_off) begin
        r_voice.gate <= 1'b0;
        r_tmr        <= '0;
      end else if (w_rel && (i_release_done || (r_tmr == TMO))) begin
        r_voice.busy <= 1'b0;
        r_tmr        <= '0;
      end else if (i_tick && w_rel && (r_tmr != TMO)) begin
        r_tmr <= r_tmr + 1'b1;
      end
      if (i_tick && r_voice.busy && (r_voice.age != AGE_MAX)) begin
        r_voice.age <= r_voice.age + 1'b1;
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Maps MIDI note-on/off events onto N_VOICES oscillator slots.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int N_VOICES        = 8,
  parameter int AGE_W           = VOICE_AGE_W,
  parameter int RELEASE_TIMEOUT = VOICE_RELEASE_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     sample_tick,
  input  logic                     note_valid,
  output logic                     note_ready,
  input  logic                     note_on,
  input  logic [6:0]               note_num,
  input  logic [6:0]               note_vel,
  input  logic                     all_off,
  input  logic [N_VOICES-1:0]      release_done,
  output logic [N_VOICES-1:0]      voice_gate,
  output logic [N_VOICES-1:0]      voice_busy,
  output logic [N_VOICES-1:0][6:0] voice_note,
  output logic [N_VOICES-1:0][6:0] voice_vel,
  output logic [N_VOICES-1:0]      voice_retrig,
  output logic                     steal
);

  localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam int CNT_W = $clog2(N_VOICES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_VOICES);

  alloc_state_t           r_state;
  alloc_state_t           w_next;
  logic [CNT_W-1:0]       r_idx;
  logic                   r_ev_on;
  logic [6:0]             r_ev_num;
  logic [6:0]             r_ev_vel;
  logic                   r_pend;
  logic                   r_steal;

  logic                   vld_p0;
  cand_cls_t              r_cls_p0;
  logic [VOICE_AGE_W-1:0] r_age_p0;
  logic [IDX_W-1:0]       r_idx_p0;

  logic                   r_best_vld;
  cand_cls_t              r_best_cls;
  logic [VOICE_AGE_W-1:0] r_best_age;
  logic [IDX_W-1:0]       r_best_idx;

  voice_t                 w_voice [N_VOICES];
  logic [N_VOICES-1:0]    w_load;
  logic [N_VOICES-1:0]    w_off;
  logic                   w_steal_nxt;
  logic                   w_hs;
  logic                   w_tick;
  logic                   w_scan_act;
  logic [IDX_W-1:0]       w_scan_idx;
  logic                   w_better;

  assign note_ready = (r_state == IDLE);
  assign w_hs       = note_valid && note_ready;
  // Ticks are applied only in IDLE so ages stay frozen while being compared.
  assign w_tick     = (r_state == IDLE) && (sample_tick || r_pend) && !all_off;
  assign w_scan_act = (r_state == SCAN) && (r_idx < LAST_CNT);
  assign w_scan_idx = w_scan_act ? r_idx[IDX_W-1:0] : '0;
  assign steal      = r_steal;

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // FSM next state; panic always returns to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_next = SCAN;
      SCAN:    if (r_idx == LAST_CNT) w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (all_off) w_next = IDLE;
  end

  // Scan cycle counter: cycle k visits voice k, one extra cycle drains the compare stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                             r_idx <= '0;
    else if (all_off || r_state != SCAN)   r_idx <= '0;
    else                                   r_idx <= r_idx + 1'b1;
  end

  // Event latch; a note-on with velocity 0 is stored as a note-off.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_ev_on  <= note_on && (note_vel != 7'd0);
      r_ev_num <= note_num;
      r_ev_vel <= note_vel;
    end
  end

  // Pending sample tick held while the FSM is busy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      r_pend <= 1'b0;
    else if (all_off)               r_pend <= 1'b0;
    else if (r_state == IDLE)       r_pend <= 1'b0;
    else if (sample_tick)           r_pend <= 1'b1;
  end

  // ---- stage p0: classify the visited voice ----
  // Candidate valid flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) vld_p0 <= 1'b0;
    else       vld_p0 <= w_scan_act && !all_off;
  end

  // Candidate data.
  always_ff @(posedge clk) begin
    r_cls_p0 <= classify(w_voice[w_scan_idx].busy, w_voice[w_scan_idx].gate,
                         w_voice[w_scan_idx].note, r_ev_num);
    r_age_p0 <= w_voice[w_scan_idx].age;
    r_idx_p0 <= w_scan_idx;
  end

  // ---- stage p1: keep the best candidate so far ----
  assign w_better = !r_best_vld ||
                    (r_cls_p0 < r_best_cls) ||
                    ((r_cls_p0 == r_best_cls) && (r_cls_p0 >= CLS_REL) &&
                     (r_age_p0 > r_best_age));

  // Best candidate valid flag, cleared whenever a new scan can start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          r_best_vld <= 1'b0;
    else if (all_off || r_state == IDLE) r_best_vld <= 1'b0;
    else if (vld_p0 && w_better)        r_best_vld <= 1'b1;
  end

  // Best candidate data; strict compares give lowest index on ties.
  always_ff @(posedge clk) begin
    if (vld_p0 && w_better) begin
      r_best_cls <= r_cls_p0;
      r_best_age <= r_age_p0;
      r_best_idx <= r_idx_p0;
    end
  end

  // ---- commit: strobes to the slots ----
  always_comb begin
    w_load      = '0;
    w_off       = '0;
    w_steal_nxt = 1'b0;
    if ((r_state == COMMIT) && !all_off) begin
      if (r_ev_on) begin
        w_load[r_best_idx] = 1'b1;
        w_steal_nxt        = (r_best_cls >= CLS_REL);
      end else begin
        for (int i = 0; i < N_VOICES; i++) begin
          w_off[i] = w_voice[i].busy && w_voice[i].gate &&
                     (w_voice[i].note == r_ev_num);
        end
      end
    end
  end

  // Steal pulse, aligned with the slot retrigger.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_steal <= 1'b0;
    else       r_steal <= w_steal_nxt;
  end

  for (genvar g = 0; g < N_VOICES; g++) begin : g_slot
    voice_slot #(
      .AGE_W          (AGE_W),
      .RELEASE_TIMEOUT(RELEASE_TIMEOUT)
    ) u_slot (
      .clk           (clk),
      .rstn          (rstn),
      .i_tick        (w_tick),
      .i_load        (w_load[g]),
      .i_off         (w_off[g]),
      .i_clear       (all_off),
      .i_note        (r_ev_num),
      .i_vel         (r_ev_vel),
      .i_release_done(release_done[g]),
      .o_voice       (w_voice[g]),
      .o_retrig      (voice_retrig[g])
    );
    assign voice_gate[g] = w_voice[g].gate;
    assign voice_busy[g] = w_voice[g].busy;
    assign voice_note[g] = w_voice[g].note;
    assign voice_vel[g]  = w_voice[g].vel;
  end

endmodule
